// File: rtl/fp_addsub_pipe.sv
// Pipelined FP add/sub, round toward zero, denormal inputs flushed to zero; one op per clock.
// Latency 5 clocks after the sampling edge (input register plus five stages); no backpressure, results leave in order.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 op_sub,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    output logic [EXP_W+MAN_W:0] out_result,
    output logic [2:0]           out_flags
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 4;
    localparam int SW   = MAN_W + 5;
    localparam int LZ_W = $clog2(MAN_W + 5);
    localparam int EXW  = EXP_W + 2;
    localparam logic [EXP_W-1:0] EMAX = EXP_W'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0] EFIN = EXP_W'((1 << EXP_W) - 2);

    typedef struct packed {
        logic         op_sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } in_t;

    typedef struct packed {
        logic             sl;
        logic [EXP_W-1:0] el;
        logic             spc;
        logic [W-1:0]     spc_res;
        logic [2:0]       spc_flg;
    } tag_t;

    typedef struct packed {
        tag_t             tag;
        logic             eff_sub;
        logic [EXP_W-1:0] d;
        logic [MAN_W:0]   ml;
        logic [MAN_W:0]   ms;
    } s1_t;

    typedef struct packed {
        tag_t          tag;
        logic          eff_sub;
        logic [MW-1:0] ml;
        logic [MW-1:0] ms;
    } s2_t;

    typedef struct packed {
        tag_t          tag;
        logic [SW-1:0] sum;
    } s3_t;

    typedef struct packed {
        tag_t            tag;
        logic [SW-1:0]   sum;
        logic [LZ_W-1:0] lzc;
    } s4_t;

    logic            in_vld_q, in_vld_d, s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic            s3_vld_q, s3_vld_d, s4_vld_q, s4_vld_d, out_valid_q, out_valid_d;
    in_t             in_q, in_d;
    s1_t             s1_q, s1_d, s1_c;
    s2_t             s2_q, s2_d, s2_c;
    s3_t             s3_q, s3_d, s3_c;
    s4_t             s4_q, s4_d, s4_c;
    logic [W-1:0]    out_result_q, out_result_d, res_c;
    logic [2:0]      out_flags_q, out_flags_d, flg_c;

    logic             sa, sb, a_ge, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic [MW-1:0]    ms_x, ms_lost, man;
    logic [EXW-1:0]   en;
    logic             uf, ovf;

    // S1: unpack, order by magnitude, decode specials into a tag that overrides the datapath
    always_comb begin
        sa     = in_q.a[W-1];
        sb     = in_q.b[W-1] ^ in_q.op_sub;
        ea     = in_q.a[W-2 -: EXP_W];
        eb     = in_q.b[W-2 -: EXP_W];
        fa     = in_q.a[MAN_W-1:0];
        fb     = in_q.b[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == EMAX) && (fa == '0);
        b_inf  = (eb == EMAX) && (fb == '0);
        a_nan  = (ea == EMAX) && (fa != '0);
        b_nan  = (eb == EMAX) && (fb != '0);
        a_ge   = in_q.a[W-2:0] >= in_q.b[W-2:0];

        s1_c            = '0;
        s1_c.tag.sl     = a_ge ? sa : sb;
        s1_c.tag.el     = a_ge ? ea : eb;
        s1_c.ml         = a_ge ? {1'b1, fa} : {1'b1, fb};
        s1_c.ms         = a_ge ? {1'b1, fb} : {1'b1, fa};
        s1_c.d          = a_ge ? (ea - eb) : (eb - ea);
        s1_c.eff_sub    = sa ^ sb;
        s1_c.tag.spc    = 1'b1;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            s1_c.tag.spc_res = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
            s1_c.tag.spc_flg = 3'b100;
        end else if (a_inf) begin
            s1_c.tag.spc_res = {sa, EMAX, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_c.tag.spc_res = {sb, EMAX, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            s1_c.tag.spc_res = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            s1_c.tag.spc_res = {sb, eb, fb};
        end else if (b_zero) begin
            s1_c.tag.spc_res = {sa, ea, fa};
        end else begin
            s1_c.tag.spc = 1'b0;
        end
    end

    // S2: align the smaller mantissa; every bit shifted past the sticky slot is ORed into it
    always_comb begin
        ms_x         = {s1_q.ms, 3'b000};
        ms_lost      = '0;
        s2_c         = '0;
        s2_c.tag     = s1_q.tag;
        s2_c.eff_sub = s1_q.eff_sub;
        s2_c.ml      = {s1_q.ml, 3'b000};
        if (int'(s1_q.d) >= MW) begin
            s2_c.ms = {{(MW-1){1'b0}}, |ms_x};
        end else begin
            ms_lost = ms_x & ~({MW{1'b1}} << s1_q.d);
            s2_c.ms = (ms_x >> s1_q.d) | {{(MW-1){1'b0}}, |ms_lost};
        end
    end

    // S3 add/subtract (L >= S so no negative result), S4 leading-zero count below the carry bit
    always_comb begin
        s3_c     = '0;
        s3_c.tag = s2_q.tag;
        s3_c.sum = s2_q.eff_sub ? ({1'b0, s2_q.ml} - {1'b0, s2_q.ms})
                                : ({1'b0, s2_q.ml} + {1'b0, s2_q.ms});
        s4_c     = '0;
        s4_c.tag = s3_q.tag;
        s4_c.sum = s3_q.sum;
        s4_c.lzc = LZ_W'(MW);
        for (int i = 0; i < MW; i++) begin
            if (s3_q.sum[i]) s4_c.lzc = LZ_W'(MW - 1 - i);
        end
    end

    // S5: normalise, truncate, then apply range limits and the special-case tag
    always_comb begin
        if (s4_q.sum[SW-1]) begin
            man    = s4_q.sum[SW-1:1];
            man[0] = s4_q.sum[1] | s4_q.sum[0];
            en     = EXW'(s4_q.tag.el) + EXW'(1);
        end else begin
            man = s4_q.sum[MW-1:0] << s4_q.lzc;
            en  = EXW'(s4_q.tag.el) - EXW'(s4_q.lzc);
        end
        uf    = en[EXW-1] || (en == '0);
        ovf   = !uf && (en >= EXW'(EMAX));
        res_c = {s4_q.tag.sl, en[EXP_W-1:0], man[MW-2:3]};
        flg_c = 3'b000;
        if (s4_q.tag.spc) begin
            res_c = s4_q.tag.spc_res;
            flg_c = s4_q.tag.spc_flg;
        end else if (s4_q.sum == '0) begin
            res_c = '0;
        end else if (uf) begin
            res_c = {s4_q.tag.sl, {(W-1){1'b0}}};
            flg_c = 3'b001;
        end else if (ovf) begin
            res_c = {s4_q.tag.sl, EFIN, {MAN_W{1'b1}}};
            flg_c = 3'b010;
        end
    end

    always_comb begin
        in_vld_d     = in_valid;
        in_d         = in_valid ? {op_sub, a, b} : in_q;
        s1_vld_d     = in_vld_q;
        s1_d         = in_vld_q ? s1_c : s1_q;
        s2_vld_d     = s1_vld_q;
        s2_d         = s1_vld_q ? s2_c : s2_q;
        s3_vld_d     = s2_vld_q;
        s3_d         = s2_vld_q ? s3_c : s3_q;
        s4_vld_d     = s3_vld_q;
        s4_d         = s3_vld_q ? s4_c : s4_q;
        out_valid_d  = s4_vld_q;
        out_result_d = s4_vld_q ? res_c : out_result_q;
        out_flags_d  = s4_vld_q ? flg_c : out_flags_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_vld_q     <= 1'b0;
            s1_vld_q     <= 1'b0;
            s2_vld_q     <= 1'b0;
            s3_vld_q     <= 1'b0;
            s4_vld_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            in_q         <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            s4_q         <= '0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            in_vld_q     <= in_vld_d;
            s1_vld_q     <= s1_vld_d;
            s2_vld_q     <= s2_vld_d;
            s3_vld_q     <= s3_vld_d;
            s4_vld_q     <= s4_vld_d;
            out_valid_q  <= out_valid_d;
            in_q         <= in_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            s4_q         <= s4_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe (binary32): directed vectors, random streaming against an exact RZ model, reset mid-stream.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, op_sub, out_valid;
    logic [31:0] a, b, out_result;
    logic [2:0]  out_flags;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    typedef struct {
        logic        vld;
        logic [34:0] exp;
    } sq_t;

    vec_t vecs[24];
    sq_t  sq[$];

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .op_sub     (op_sub),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) $display("FAIL %s: got %h want %h", nm, act, expv);
        else n_pass++;
    endtask

    // Exact reference: both significands placed in a 128-bit integer, the true result truncated.
    function automatic logic [34:0] ref_model(input logic [31:0] x, input logic [31:0] y, input logic sub);
        logic        sx, sy, xn, yn, xi, yi, sl, ss;
        int          ex, ey, el, es, d, p, e;
        logic [22:0] fx, fy, fl, fs, fr;
        logic [127:0] big, sm, r, t;
        sx = x[31]; sy = y[31] ^ sub;
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        fx = x[22:0]; fy = y[22:0];
        xn = (ex == 255) && (fx != 0); yn = (ey == 255) && (fy != 0);
        xi = (ex == 255) && (fx == 0); yi = (ey == 255) && (fy == 0);
        if (xn || yn || (xi && yi && (sx != sy))) return {3'b100, 32'h7FC00000};
        if (xi) return {3'b000, sx, 8'hFF, 23'h0};
        if (yi) return {3'b000, sy, 8'hFF, 23'h0};
        if (ex == 0 && ey == 0) return {3'b000, sx & sy, 31'h0};
        if (ex == 0) return {3'b000, sy, y[30:0]};
        if (ey == 0) return {3'b000, sx, x[30:0]};
        if (x[30:0] >= y[30:0]) begin
            sl = sx; el = ex; fl = fx; ss = sy; es = ey; fs = fy;
        end else begin
            sl = sy; el = ey; fl = fy; ss = sx; es = ex; fs = fx;
        end
        d   = el - es;
        big = {104'h0, 1'b1, fl} << 64;
        if (d > 64) sm = (sl != ss) ? 128'h1 : 128'h0;
        else        sm = {104'h0, 1'b1, fs} << (64 - d);
        r = (sl != ss) ? (big - sm) : (big + sm);
        if (r == 0) return {3'b000, 32'h0};
        p = 0;
        for (int i = 0; i < 128; i++) if (r[i]) p = i;
        e = el + p - 87;
        if (e <= 0) return {3'b001, sl, 31'h0};
        if (e >= 255) return {3'b010, sl, 8'hFE, 23'h7FFFFF};
        t  = r >> (p - 23);
        fr = t[22:0];
        return {3'b000, sl, e[7:0], fr};
    endfunction

    task automatic run_vec(input int idx);
        @(negedge clk);
        in_valid = 1'b1; a = vecs[idx].a; b = vecs[idx].b; op_sub = vecs[idx].sub;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk($sformatf("v%0d_early_vld", idx), 64'(out_valid), 64'd0);
        @(negedge clk);
        chk($sformatf("v%0d_vld", idx), 64'(out_valid), 64'd1);
        chk($sformatf("v%0d_res", idx), 64'(out_result), 64'(vecs[idx].res));
        chk($sformatf("v%0d_flags", idx), 64'(out_flags), 64'(vecs[idx].flg));
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          ee, issued, cyc;
        sq_t         e;

        vecs[0]  = '{32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 3'b000};
        vecs[1]  = '{32'h40100000, 32'h3FC00000, 1'b0, 32'h40700000, 3'b000};
        vecs[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
        vecs[3]  = '{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 3'b000};
        vecs[4]  = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000};
        vecs[5]  = '{32'h3F7FFFFF, 32'h3F800000, 1'b1, 32'hB3800000, 3'b000};
        vecs[6]  = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 3'b000};
        vecs[7]  = '{32'h3F800000, 32'h4B800000, 1'b0, 32'h4B800000, 3'b000};
        vecs[8]  = '{32'h3F800000, 32'h33000000, 1'b0, 32'h3F800000, 3'b000};
        vecs[9]  = '{32'h3F800000, 32'h33000000, 1'b1, 32'h3F7FFFFF, 3'b000};
        vecs[10] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 3'b010};
        vecs[11] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100};
        vecs[12] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001};
        vecs[13] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000};
        vecs[14] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000};
        vecs[15] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100};
        vecs[16] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
        vecs[17] = '{32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 3'b000};
        vecs[18] = '{32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 3'b000};
        vecs[19] = '{32'h40400000, 32'h00000000, 1'b0, 32'h40400000, 3'b000};
        vecs[20] = '{32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000};
        vecs[21] = '{32'hC0000000, 32'h3F800000, 1'b1, 32'hC0400000, 3'b000};
        vecs[22] = '{32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF7FFFFF, 3'b010};
        vecs[23] = '{32'h007FFFFF, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000};

        rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        #12;
        chk("reset_vld", 64'(out_valid), 64'd0);
        chk("reset_res", 64'(out_result), 64'd0);
        chk("reset_flags", 64'(out_flags), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) run_vec(i);

        // Random stream with bubbles; each slot is checked exactly 5 edges after its sampling edge.
        for (int i = 0; i < 6; i++) sq.push_back('{1'b0, 35'h0});
        issued = 0; cyc = 0;
        while (issued < 1000 && cyc < 5000) begin
            @(negedge clk);
            e = sq.pop_front();
            if (e.vld) chk("stream", {28'h0, out_valid, out_flags, out_result}, {28'h0, 1'b1, e.exp});
            else       chk("stream_bubble", 64'(out_valid), 64'd0);
            ra = $urandom; rs = 1'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    ee = int'(ra[30:23]) + int'($urandom_range(0, 6)) - 3;
                    if (ee < 0) ee = 0;
                    if (ee > 255) ee = 255;
                    rb = {1'($urandom), 8'(ee), 23'($urandom)};
                end
                4: rb = ra ^ 32'h1;
                5: rb = {1'($urandom), ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00,
                         ($urandom_range(0, 1) != 0) ? 23'($urandom) : 23'h0};
                6: begin
                    ra[30:23] = 8'($urandom_range(1, 3));
                    rb = {1'($urandom), ra[30:23], 23'($urandom)};
                end
                7: begin
                    ra[30:23] = 8'hFE;
                    rb = {1'($urandom), 8'($urandom_range(250, 254)), 23'($urandom)};
                end
                default: rb = $urandom;
            endcase
            a = ra; b = rb; op_sub = rs;
            in_valid = ($urandom_range(0, 3) != 0);
            if (in_valid) begin
                sq.push_back('{1'b1, ref_model(ra, rb, rs)});
                issued++;
            end else begin
                sq.push_back('{1'b0, 35'h0});
            end
            cyc++;
        end
        chk("stream_issued", 64'(issued), 64'd1000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            e = sq.pop_front();
            if (e.vld) chk("stream_tail", {28'h0, out_valid, out_flags, out_result}, {28'h0, 1'b1, e.exp});
            else       chk("stream_tail_bubble", 64'(out_valid), 64'd0);
        end

        // Leave a known nonzero result on the outputs, then reset with three ops in flight.
        run_vec(20);
        @(negedge clk); in_valid = 1'b1; a = 32'h3FC00000; b = 32'h40100000; op_sub = 1'b0;
        @(negedge clk); a = 32'h7F7FFFFF; b = 32'h7F7FFFFF;
        @(negedge clk); a = 32'h7F800000; b = 32'h7F800000; op_sub = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(out_valid), 64'd0);
        chk("arst_res", 64'(out_result), 64'd0);
        chk("arst_flags", 64'(out_flags), 64'd0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("arst_flush_%0d", i), {31'h0, out_valid, out_result}, 64'd0);
        end
        run_vec(4);
        run_vec(12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
